// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state
// encoding, byte-strobe constants and the misalignment predicate.
package lsu_pkg;

   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;

   localparam logic [3:0] WSTRB_NONE = 4'b0000;
   localparam logic [3:0] WSTRB_B    = 4'b0001;
   localparam logic [3:0] WSTRB_H    = 4'b0011;
   localparam logic [3:0] WSTRB_W    = 4'b1111;

   // Halfwords must sit on even addresses, words on multiples of four;
   // unknown widths are words.
   function automatic logic lsu_is_misaligned(input logic [2:0] funct3,
                                              input logic [1:0] offset);
      case (funct3)
         LSU_B, LSU_BU: return 1'b0;
         LSU_H, LSU_HU: return offset[0];
         default:       return (offset != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Memory request/response port of the load/store unit.
// master = load/store unit, slave = memory.
interface lsu_if;

   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_write;
   logic [31:0] mem_req_address;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_wstrb;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_rdata;

   modport master (
      output mem_req_valid, mem_req_write, mem_req_address,
             mem_req_wdata, mem_req_wstrb,
      input  mem_req_ready, mem_resp_valid, mem_resp_rdata
   );

   modport slave (
      input  mem_req_valid, mem_req_write, mem_req_address,
             mem_req_wdata, mem_req_wstrb,
      output mem_req_ready, mem_resp_valid, mem_resp_rdata
   );

endinterface

// File: rtl/lsu_load_align.sv
// Load data extraction: picks the byte/halfword lane out of the returned
// word and sign- or zero-extends it to 32 bits.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_offset,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Lane selection and extension.
   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_byte   = i_rdata[7:0];
      w_half   = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
      o_result = i_rdata;
      case (i_offset)
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         2'd3:    w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
      case (i_funct3)
         LSU_B:   o_result = {{24{w_byte[7]}}, w_byte};
         LSU_BU:  o_result = {24'b0, w_byte};
         LSU_H:   o_result = {{16{w_half[15]}}, w_half};
         LSU_HU:  o_result = {16'b0, w_half};
         default: o_result = i_rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage behind the ALU: one byte/halfword/word load or store per
// accepted instruction over a valid/ready memory port, with a response
// timeout. Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned
// halfword/word accesses complete immediately with o_lsu_misaligned and
// issue no memory request).
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned RESP_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_lsu_valid,
   input  logic        i_lsu_mem_read,
   input  logic        i_lsu_mem_write,
   input  logic [2:0]  i_lsu_funct3,
   input  logic [31:0] i_lsu_address,
   input  logic [31:0] i_lsu_store_data,
   output logic        o_lsu_busy,
   output logic        o_lsu_done,
   output logic [31:0] o_lsu_load_data,
   output logic        o_lsu_misaligned,
   output logic        o_lsu_timeout,
   lsu_if.master       mem
);

   lsu_state_e  r_state;
   logic [31:0] r_cnt;
   logic        r_done;
   logic        r_misaligned;
   logic        r_timeout;
   logic [31:0] r_load_data;
   logic        r_req_valid;
   logic        r_req_write;
   logic [31:0] r_req_address;
   logic [31:0] r_req_wdata;
   logic [3:0]  r_req_wstrb;
   logic [2:0]  r_funct3;
   logic [1:0]  r_offset;

   logic        w_accept;
   logic        w_misalign;
   logic        w_tout_hit;
   logic [1:0]  w_off;
   logic [3:0]  w_wstrb;
   logic [31:0] w_wdata;
   logic [31:0] w_aligned;

   assign w_off    = i_lsu_address[1:0];
   assign w_accept = (r_state == ST_IDLE) && i_lsu_valid &&
                     (i_lsu_mem_read ^ i_lsu_mem_write);

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_misalign = w_accept && lsu_is_misaligned(i_lsu_funct3, w_off);
`else
   assign w_misalign = 1'b0;
`endif

   // Timeout fires on the cycle that would bring the count to RESP_TIMEOUT.
   assign w_tout_hit = (RESP_TIMEOUT != 0) && (r_cnt == RESP_TIMEOUT - 1);

   assign o_lsu_busy = (r_state == ST_REQ) || (r_state == ST_RESP) || w_accept;

   // Store lane placement: strobes from the offset, data replicated per lane.
   always_comb begin
      w_wstrb = WSTRB_NONE;
      w_wdata = '0;
      if (i_lsu_mem_write) begin
         case (i_lsu_funct3)
            LSU_B, LSU_BU: begin
               w_wstrb = WSTRB_B << w_off;
               w_wdata = {4{i_lsu_store_data[7:0]}};
            end
            LSU_H, LSU_HU: begin
               w_wstrb = WSTRB_H << {w_off[1], 1'b0};
               w_wdata = {2{i_lsu_store_data[15:0]}};
            end
            default: begin
               w_wstrb = WSTRB_W;
               w_wdata = i_lsu_store_data;
            end
         endcase
      end
   end

   lsu_load_align u_load_align (
      .i_rdata  (mem.mem_resp_rdata),
      .i_offset (r_offset),
      .i_funct3 (r_funct3),
      .o_result (w_aligned)
   );

   // Access FSM with registered request fields and completion flags.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_done        <= 1'b0;
         r_misaligned  <= 1'b0;
         r_timeout     <= 1'b0;
         r_load_data   <= '0;
         r_req_valid   <= 1'b0;
         r_req_write   <= 1'b0;
         r_req_address <= '0;
         r_req_wdata   <= '0;
         r_req_wstrb   <= '0;
         r_funct3      <= '0;
         r_offset      <= '0;
      end else begin
         r_done       <= 1'b0;
         r_misaligned <= 1'b0;
         r_timeout    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_cnt         <= '0;
                  r_req_write   <= i_lsu_mem_write;
                  r_req_address <= {i_lsu_address[31:2], 2'b00};
                  r_req_wdata   <= w_wdata;
                  r_req_wstrb   <= w_wstrb;
                  r_funct3      <= i_lsu_funct3;
                  r_offset      <= w_off;
                  if (w_misalign) begin
                     r_state      <= ST_DONE;
                     r_done       <= 1'b1;
                     r_misaligned <= 1'b1;
                  end else begin
                     r_state     <= ST_REQ;
                     r_req_valid <= 1'b1;
                  end
               end
            end
            ST_REQ: begin
               r_cnt <= r_cnt + 32'd1;
               if (mem.mem_req_ready) begin
                  r_req_valid <= 1'b0;
                  if (r_req_write) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_RESP;
                  end
               end else if (w_tout_hit) begin
                  r_req_valid <= 1'b0;
                  r_state     <= ST_DONE;
                  r_done      <= 1'b1;
                  r_timeout   <= 1'b1;
               end
            end
            ST_RESP: begin
               r_cnt <= r_cnt + 32'd1;
               if (mem.mem_resp_valid) begin
                  r_load_data <= w_aligned;
                  r_state     <= ST_DONE;
                  r_done      <= 1'b1;
               end else if (w_tout_hit) begin
                  r_state   <= ST_DONE;
                  r_done    <= 1'b1;
                  r_timeout <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_lsu_done          = r_done;
   assign o_lsu_misaligned    = r_misaligned;
   assign o_lsu_timeout       = r_timeout;
   assign o_lsu_load_data     = r_load_data;
   assign mem.mem_req_valid   = r_req_valid;
   assign mem.mem_req_write   = r_req_write;
   assign mem.mem_req_address = r_req_address;
   assign mem.mem_req_wdata   = r_req_wdata;
   assign mem.mem_req_wstrb   = r_req_wstrb;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (RESP_TIMEOUT = 8). Expected completion
// results go into a scoreboard queue when an access is driven and are popped
// when o_lsu_done pulses.
module tb_load_store_unit;
   import lsu_pkg::*;

   typedef struct {
      logic [31:0] data;
      logic        mis;
      logic        tout;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lsu_valid, lsu_mem_read, lsu_mem_write;
   logic [2:0]  lsu_funct3;
   logic [31:0] lsu_address, lsu_store_data;
   logic        lsu_busy, lsu_done, lsu_misaligned, lsu_timeout;
   logic [31:0] lsu_load_data;

   lsu_if mem_if ();

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   load_store_unit #(.RESP_TIMEOUT(8)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_lsu_valid      (lsu_valid),
      .i_lsu_mem_read   (lsu_mem_read),
      .i_lsu_mem_write  (lsu_mem_write),
      .i_lsu_funct3     (lsu_funct3),
      .i_lsu_address    (lsu_address),
      .i_lsu_store_data (lsu_store_data),
      .o_lsu_busy       (lsu_busy),
      .o_lsu_done       (lsu_done),
      .o_lsu_load_data  (lsu_load_data),
      .o_lsu_misaligned (lsu_misaligned),
      .o_lsu_timeout    (lsu_timeout),
      .mem              (mem_if)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=no finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic wr, input logic rd, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
      lsu_valid      = 1'b1;
      lsu_mem_read   = rd;
      lsu_mem_write  = wr;
      lsu_funct3     = f3;
      lsu_address    = a;
      lsu_store_data = d;
   endtask

   task automatic idle_inputs();
      lsu_valid     = 1'b0;
      lsu_mem_read  = 1'b0;
      lsu_mem_write = 1'b0;
   endtask

   // Pops the scoreboard at a done cycle and compares completion outputs.
   task automatic score(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb_q.pop_front();
      check({tag, "_load_data"}, lsu_load_data, e.data);
      check({tag, "_misaligned"}, {31'b0, lsu_misaligned}, {31'b0, e.mis});
      check({tag, "_timeout"}, {31'b0, lsu_timeout}, {31'b0, e.tout});
      check({tag, "_busy_done"}, {31'b0, lsu_busy}, 32'd0);
   endtask

   // One full access, called just after a rising edge. ready_wait cycles of
   // held-off ready, optional response on the cycle after the handshake.
   task automatic run_access(input string tag, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d,
                             input int ready_wait, input bit give_resp,
                             input logic [31:0] rdata, input logic [31:0] exp_addr,
                             input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                             input int exp_lat, input logic [31:0] exp_data,
                             input logic exp_tout);
      int  cyc;
      bit  seen;
      drive(wr, !wr, f3, a, d);
      sb_q.push_back('{data: exp_data, mis: 1'b0, tout: exp_tout});
      @(negedge clk);
      check({tag, "_busy_accept"}, {31'b0, lsu_busy}, 32'd1);
      next_cycle();
      idle_inputs();
      cyc = 1;
      for (int w = 0; w <= ready_wait; w++) begin
         @(negedge clk);
         check({tag, "_req_valid"}, {31'b0, mem_if.mem_req_valid}, 32'd1);
         check({tag, "_req_addr"}, mem_if.mem_req_address, exp_addr);
         check({tag, "_req_wstrb"}, {28'b0, mem_if.mem_req_wstrb}, {28'b0, exp_wstrb});
         check({tag, "_req_write"}, {31'b0, mem_if.mem_req_write}, {31'b0, wr});
         if (wr) check({tag, "_req_wdata"}, mem_if.mem_req_wdata, exp_wdata);
         check({tag, "_busy_req"}, {31'b0, lsu_busy}, 32'd1);
         if (w == ready_wait) mem_if.mem_req_ready = 1'b1;
         next_cycle();
         mem_if.mem_req_ready = 1'b0;
         cyc++;
      end
      if (!wr && give_resp) begin
         @(negedge clk);
         check({tag, "_req_dropped"}, {31'b0, mem_if.mem_req_valid}, 32'd0);
         mem_if.mem_resp_valid = 1'b1;
         mem_if.mem_resp_rdata = rdata;
         next_cycle();
         mem_if.mem_resp_valid = 1'b0;
         mem_if.mem_resp_rdata = 32'h0;
         cyc++;
      end
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (lsu_done) seen = 1'b1;
         else begin
            next_cycle();
            cyc++;
         end
      end
      check({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
      if (seen) begin
         check({tag, "_latency"}, cyc, exp_lat);
         score(tag);
      end else begin
         void'(sb_q.pop_front());
      end
      next_cycle();
      @(negedge clk);
      check({tag, "_done_pulse"}, {31'b0, lsu_done}, 32'd0);
      next_cycle();
   endtask

   initial begin
      logic [31:0] last_load;
      rst_n = 1'b0;
      idle_inputs();
      lsu_funct3 = 3'b0;
      lsu_address = 32'h0;
      lsu_store_data = 32'h0;
      mem_if.mem_req_ready  = 1'b0;
      mem_if.mem_resp_valid = 1'b0;
      mem_if.mem_resp_rdata = 32'h0;
      last_load = 32'h0;

      // Reset state
      #2;
      check("rst_busy", {31'b0, lsu_busy}, 32'd0);
      check("rst_done", {31'b0, lsu_done}, 32'd0);
      check("rst_load_data", lsu_load_data, 32'd0);
      check("rst_flags", {30'b0, lsu_misaligned, lsu_timeout}, 32'd0);
      check("rst_req_valid", {31'b0, mem_if.mem_req_valid}, 32'd0);
      check("rst_req_fields", mem_if.mem_req_address | mem_if.mem_req_wdata |
            {27'b0, mem_if.mem_req_write, mem_if.mem_req_wstrb}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();

      // Loads with extension
      run_access("lb_103", 1'b0, LSU_B, 32'h0000_0103, 32'h0, 0, 1'b1, 32'h80FF_0000,
                 32'h0000_0100, 32'h0, 4'b0000, 3, 32'hFFFF_FF80, 1'b0);
      run_access("lhu_202", 1'b0, LSU_HU, 32'h0000_0202, 32'h0, 0, 1'b1, 32'hBEEF_1234,
                 32'h0000_0200, 32'h0, 4'b0000, 3, 32'h0000_BEEF, 1'b0);
      run_access("lh_202", 1'b0, LSU_H, 32'h0000_0202, 32'h0, 0, 1'b1, 32'hBEEF_1234,
                 32'h0000_0200, 32'h0, 4'b0000, 3, 32'hFFFF_BEEF, 1'b0);
      last_load = 32'hFFFF_BEEF;

      // Stores
      run_access("sb_1001", 1'b1, LSU_B, 32'h0000_1001, 32'h0000_00A5, 0, 1'b0, 32'h0,
                 32'h0000_1000, 32'hA5A5_A5A5, 4'b0010, 2, last_load, 1'b0);
      run_access("sh_1006", 1'b1, LSU_H, 32'h0000_1006, 32'h1234_5678, 0, 1'b0, 32'h0,
                 32'h0000_1004, 32'h5678_5678, 4'b1100, 2, last_load, 1'b0);
      run_access("sw_stall", 1'b1, LSU_W, 32'h0000_3000, 32'hDEAD_BEEF, 5, 1'b0, 32'h0,
                 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111, 7, last_load, 1'b0);

      // Load with no response: timeout after 8 cycles in REQ/RESP
      run_access("lw_tout", 1'b0, LSU_W, 32'h0000_0400, 32'h0, 0, 1'b0, 32'h0,
                 32'h0000_0400, 32'h0, 4'b0000, 9, last_load, 1'b1);

      // Reset pulsed while a load waits in RESP
      drive(1'b0, 1'b1, LSU_W, 32'h0000_0040, 32'h0);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      mem_if.mem_req_ready = 1'b1;
      next_cycle();
      mem_if.mem_req_ready = 1'b0;
      #2;
      check("midresp_busy", {31'b0, lsu_busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'b0, lsu_busy}, 32'd0);
      check("midrst_load_data", lsu_load_data, 32'd0);
      check("midrst_req_valid", {31'b0, mem_if.mem_req_valid}, 32'd0);
      check("midrst_req_fields", mem_if.mem_req_address | mem_if.mem_req_wdata |
            {27'b0, mem_if.mem_req_write, mem_if.mem_req_wstrb}, 32'd0);
      check("midrst_flags", {29'b0, lsu_done, lsu_misaligned, lsu_timeout}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
      last_load = 32'h0;

      // Word at a misaligned address
`ifdef LSU_MISALIGN_TRAP_EN
      drive(1'b0, 1'b1, LSU_W, 32'h0000_0002, 32'h0);
      sb_q.push_back('{data: last_load, mis: 1'b1, tout: 1'b0});
      @(negedge clk);
      check("lw_mis_busy_accept", {31'b0, lsu_busy}, 32'd1);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      check("lw_mis_no_req", {31'b0, mem_if.mem_req_valid}, 32'd0);
      check("lw_mis_done", {31'b0, lsu_done}, 32'd1);
      score("lw_mis");
      next_cycle();
`else
      run_access("lw_002", 1'b0, LSU_W, 32'h0000_0002, 32'h0, 0, 1'b1, 32'h1122_3344,
                 32'h0000_0000, 32'h0, 4'b0000, 3, 32'h1122_3344, 1'b0);
`endif

      // Both read and write set: no access, no done
      drive(1'b1, 1'b1, LSU_W, 32'h0000_0500, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("both_busy", {31'b0, lsu_busy}, 32'd0);
         check("both_no_req", {30'b0, mem_if.mem_req_valid, lsu_done}, 32'd0);
         next_cycle();
      end
      idle_inputs();

      check("sb_drained", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory stage directly downstream of the ALU.
- Takes the ALU result as the effective address, plus rs2 data as store data.
- Performs one byte/halfword/word load or store per request over a valid/ready memory port.
- Returns aligned, sign- or zero-extended load data to writeback.
- Stalls the pipeline while an access is outstanding.

## Interface
- RESP_TIMEOUT, 64, cycles allowed in REQ+RESP before abort; 0 disables the timeout
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- lsu_valid  in  1  execute-stage instruction present
- lsu_mem_read  in  1  instruction is a load
- lsu_mem_write  in  1  instruction is a store
- lsu_funct3  in  3  width/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu; 011/110/111 treated as w
- lsu_address  in  32  effective address (ALU output)
- lsu_store_data  in  32  store source register value
- lsu_busy  out  1  combinational stall request to upstream
- lsu_done  out  1  one-cycle completion pulse
- lsu_load_data  out  32  extended load result
- lsu_misaligned  out  1  access aborted for misalignment; valid with lsu_done
- lsu_timeout  out  1  access aborted by timeout; valid with lsu_done
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_write  out  1  1 = store
- mem_req_address  out  32  word address, bits [1:0] = 0
- mem_req_wdata  out  32  lane-replicated store data
- mem_req_wstrb  out  4  byte enables (0000 for loads)
- mem_resp_valid  in  1  load data valid
- mem_resp_rdata  in  32  load word

## Operation
- FSM states:
  - IDLE: accept when lsu_valid and exactly one of lsu_mem_read/lsu_mem_write is set; capture address, data, funct3 and kind into registers; go to REQ. Both or neither set means no access and no lsu_done.
  - REQ: mem_req_valid=1; all request fields held from registers. On mem_req_ready, a store goes to DONE and a load goes to RESP.
  - RESP: on mem_resp_valid, register the extended data into lsu_load_data; go to DONE.
  - DONE: lsu_done=1 for one cycle; go to IDLE unconditionally. lsu_valid is ignored in DONE.
- lsu_busy = (REQ or RESP) or (IDLE and an accept condition is present). It is low in DONE so the pipeline advances on the completion cycle.
- Store lanes, with o = address[1:0]:
  - sb: wstrb = 0001<<o; wdata = {4{data[7:0]}}.
  - sh: wstrb = 0011<<{o[1],0}; wdata = {2{data[15:0]}}.
  - sw: wstrb = 1111; wdata = data.
- Load extraction:
  - Byte lane o; halfword lane o[1].
  - b/h sign-extend; bu/hu zero-extend; w passes through.
- Timeout counter:
  - Cleared on accept; increments every cycle in REQ/RESP.
  - When it reaches RESP_TIMEOUT (if nonzero), go to DONE with lsu_timeout=1 and deassert mem_req_valid.
  - lsu_load_data is unchanged on timeout.
- mem_resp_valid outside RESP is ignored. A response never arrives in the same cycle as the request handshake.
- lsu_misaligned and lsu_timeout are 0 except in DONE.
- lsu_load_data holds until the next successful load.

## Timing
- Reset (async, rst=0):
  - State returns to IDLE; counter clears.
  - All outputs are 0, including lsu_load_data and the mem_req_* fields.
  - Any outstanding request or response is abandoned; the memory side is reset together with this block.
- Accept at cycle T puts REQ at T+1, where mem_req_valid first rises (registered).
- Store with ready at T+1: DONE at T+2.
- Load with ready at T+1 and response at T+2: DONE at T+3, with lsu_load_data valid from T+3.
- The next access is accepted no earlier than DONE+1.
- mem_req_valid remains high until handshake or timeout. Request fields never change while it is high.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A halfword with address[0]=1 or a word with address[1:0]!=0 issues no memory request.
  - The FSM goes IDLE→DONE with lsu_misaligned=1; busy is 1 for the accept cycle only.
- Undefined:
  - Offending low bits are ignored (halfword uses lane address[1]; word uses lane 0).
  - lsu_misaligned is tied 0.

## Structure
- Package lsu_pkg holds:
  - funct3 localparams (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU);
  - FSM state encoding (2 bits);
  - wstrb constants.
- Sub-module lsu_load_align: combinational lane select and extension (inputs rdata, offset, funct3; output 32-bit result).

## Test plan
- lb at address 0x103, rdata 0x80FF_0000 → lsu_load_data 0xFFFF_FF80; lsu_done at T+3 with ready and response both at earliest.
- lhu at 0x202, rdata 0xBEEF_1234 → 0x0000_BEEF; lh at the same address → 0xFFFF_BEEF.
- sb at 0x1001, data 0x0000_00A5 → mem_req_address 0x1000, wstrb 0010, wdata 0xA5A5_A5A5; lsu_done at T+2.
- sw with mem_req_ready low for 5 cycles → mem_req_valid and fields stable for 6 cycles; lsu_busy high until DONE.
- Load with no response and RESP_TIMEOUT=8 → lsu_done with lsu_timeout=1 after 8 cycles in REQ/RESP; rst pulsed mid-RESP on another access → all outputs 0 immediately, IDLE.
- lw at 0x2 → with LSU_MISALIGN_TRAP_EN: no mem_req_valid, lsu_misaligned=1 at T+1; without: request to 0x0, wstrb 0000.
